// File: rtl/apb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// apb_rr_arbiter
//   Arbitrates NS APB requesters onto one shared APB target. A round-robin
//   pointer picks the winner in IDLE. The winner's address, write data and
//   direction are latched, and the block then runs its own SETUP and ACCESS
//   phases on the master side. The result goes back to the winner as a
//   one-cycle registered response. A watchdog aborts any ACCESS phase that
//   runs TIMEOUT cycles without PREADY. Setting TIMEOUT to 0 disables it.
//
// Requester handshake (valid/ready): a requester holds APBS_PSEL[i] with a
//   stable PADDR/PWDATA/PWRITE until it sees APBS_PREADY[i]=1. The request
//   is sampled only on the IDLE cycle in which it is granted. The requester
//   drops PSEL during the response cycle. The IDLE cycle that always follows
//   the response guarantees that a stale PSEL is never granted again.
//
// Ports
//   CLK, RESET             clock; synchronous active-high reset
//   APBS_PSEL/PENABLE      per-requester select / enable (enable unused)
//   APBS_PADDR/PWDATA      packed per-requester address / write data
//   APBS_PWRITE            per-requester direction
//   APBS_PRDATA            shared registered read data (held until next capture)
//   APBS_PREADY/PSLVERR    one-hot completion pulse / error for the winner
//   APBM_*                 master-side APB towards the shared target
//   GRANT                  one-hot current owner, 0 in IDLE
//   TIMEOUT_EVT            one-cycle pulse when the watchdog aborts a transfer
// ---------------------------------------------------------------------------
module apb_rr_arbiter #(
  parameter int NS      = 4,
  parameter int DW      = 32,
  parameter int AW      = 16,
  parameter int TIMEOUT = 255
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [NS-1:0]    APBS_PSEL,
  input  logic [NS-1:0]    APBS_PENABLE,
  input  logic [NS*AW-1:0] APBS_PADDR,
  input  logic [NS*DW-1:0] APBS_PWDATA,
  input  logic [NS-1:0]    APBS_PWRITE,
  output logic [DW-1:0]    APBS_PRDATA,
  output logic [NS-1:0]    APBS_PREADY,
  output logic [NS-1:0]    APBS_PSLVERR,
  output logic             APBM_PSEL,
  output logic             APBM_PENABLE,
  output logic [AW-1:0]    APBM_PADDR,
  output logic [DW-1:0]    APBM_PWDATA,
  output logic             APBM_PWRITE,
  input  logic [DW-1:0]    APBM_PRDATA,
  input  logic             APBM_PREADY,
  input  logic             APBM_PSLVERR,
  output logic [NS-1:0]    GRANT,
  output logic             TIMEOUT_EVT
);

  localparam int PW = $clog2(NS);
  // A 1-bit counter is kept when the watchdog is disabled. The counter then
  // never counts.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  logic [1:0]    state;
  logic [PW-1:0] last;
  logic [CW-1:0] wd_cnt;

  logic          pick_valid;
  logic [PW-1:0] pick_idx;
  logic [PW-1:0] cand;
  logic [NS-1:0] pick_onehot;
  logic          wd_hit;

  // PENABLE only matters for the requester's own protocol.
  logic          unused_penable;
  assign unused_penable = ^APBS_PENABLE;

  // The scan starts at the requester after the last winner and wraps. The
  // last winner therefore has the lowest priority.
  always_comb begin
    pick_valid  = 1'b0;
    pick_idx    = '0;
    cand        = '0;
    for (int i = 1; i <= NS; i++) begin
      cand = PW'((int'(last) + i) % NS);
      if (!pick_valid && APBS_PSEL[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
    pick_onehot = '0;
    pick_onehot[pick_idx] = 1'b1;
  end

  assign wd_hit = (TIMEOUT != 0) && (wd_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state        <= S_IDLE;
      last         <= PW'(NS - 1);
      wd_cnt       <= '0;
      APBS_PRDATA  <= '0;
      APBS_PREADY  <= '0;
      APBS_PSLVERR <= '0;
      APBM_PSEL    <= 1'b0;
      APBM_PENABLE <= 1'b0;
      APBM_PADDR   <= '0;
      APBM_PWDATA  <= '0;
      APBM_PWRITE  <= 1'b0;
      GRANT        <= '0;
      TIMEOUT_EVT  <= 1'b0;
    end else begin
      TIMEOUT_EVT <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pick_valid) begin
            APBM_PADDR   <= APBS_PADDR[pick_idx*AW +: AW];
            APBM_PWDATA  <= APBS_PWDATA[pick_idx*DW +: DW];
            APBM_PWRITE  <= APBS_PWRITE[pick_idx];
            APBM_PSEL    <= 1'b1;
            APBM_PENABLE <= 1'b0;
            GRANT        <= pick_onehot;
            last         <= pick_idx;
            state        <= S_SETUP;
          end
        end
        S_SETUP: begin
          APBM_PENABLE <= 1'b1;
          wd_cnt       <= '0;
          state        <= S_ACCESS;
        end
        S_ACCESS: begin
          // Target completion wins over a watchdog expiry in the same cycle.
          if (APBM_PREADY) begin
            APBS_PRDATA  <= APBM_PRDATA;
            APBS_PREADY  <= GRANT;
            APBS_PSLVERR <= APBM_PSLVERR ? GRANT : '0;
            APBM_PSEL    <= 1'b0;
            APBM_PENABLE <= 1'b0;
            state        <= S_RESP;
          end else if (wd_hit) begin
            APBS_PRDATA  <= '0;
            APBS_PREADY  <= GRANT;
            APBS_PSLVERR <= GRANT;
            TIMEOUT_EVT  <= 1'b1;
            APBM_PSEL    <= 1'b0;
            APBM_PENABLE <= 1'b0;
            state        <= S_RESP;
          end else if (TIMEOUT != 0) begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        S_RESP: begin
          APBS_PREADY  <= '0;
          APBS_PSLVERR <= '0;
          GRANT        <= '0;
          state        <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/apb_rr_arbiter.md
Name: apb_rr_arbiter

Overview:
- NS-requester to 1-target APB arbiter/sequencer with round-robin fairness and a per-transfer watchdog.
- Requesters are APB masters on packed slave-side ports. The block registers the winner's request and drives its own APB master phases (SETUP, ACCESS) to the shared target.
- Returns a one-cycle registered response to the winner.
- Sits in front of shared register banks where several bus bridges or engines contend.

Parameters:
- NS, 4, number of requesters (2..16).
- DW, 32, data width.
- AW, 16, address width.
- TIMEOUT, 255, max ACCESS cycles before abort; 0 disables the watchdog.

Ports:
- CLK  in  1  clock, all logic on rising edge.
- RESET  in  1  reset; synchronous, active-high.
- APBS_PSEL  in  NS  per-requester select.
- APBS_PENABLE  in  NS  per-requester enable (ignored for arbitration; requester protocol only).
- APBS_PADDR  in  NS*AW  packed addresses; requester i at bits [i*AW +: AW].
- APBS_PWDATA  in  NS*DW  packed write data; same packing.
- APBS_PWRITE  in  NS  per-requester write flag.
- APBS_PRDATA  out  DW  shared registered read data.
- APBS_PREADY  out  NS  one-hot completion pulse.
- APBS_PSLVERR  out  NS  error flag, valid with PREADY.
- APBM_PSEL  out  1  master select.
- APBM_PENABLE  out  1  master enable.
- APBM_PADDR  out  AW  latched address.
- APBM_PWDATA  out  DW  latched write data.
- APBM_PWRITE  out  1  latched direction.
- APBM_PRDATA  in  DW  target read data.
- APBM_PREADY  in  1  target ready.
- APBM_PSLVERR  in  1  target error.
- GRANT  out  NS  one-hot current owner; 0 in IDLE.
- TIMEOUT_EVT  out  1  one-cycle pulse on watchdog abort.

Behaviour:
- States: IDLE, SETUP, ACCESS, RESP.
- Reset (RESET=1 at a clock edge):
  - State goes to IDLE.
  - All outputs go to 0.
  - Round-robin pointer (last granted) goes to NS-1, so requester 0 has highest priority first.
  - Watchdog counter goes to 0.
  - Reset mid-transfer abandons the master transfer immediately (APBM_PSEL=0 next cycle); no response is given.
- IDLE:
  - If any APBS_PSEL, pick the first set bit scanning from (last+1) mod NS upward with wrap.
  - Latch its PADDR/PWDATA/PWRITE into the APBM_* registers and set GRANT and last.
  - Next state SETUP: APBM_PSEL=1, APBM_PENABLE=0.
  - If no APBS_PSEL, stay in IDLE.
- SETUP: exactly one cycle, then ACCESS (APBM_PENABLE=1); watchdog counter cleared.
- ACCESS:
  - APBM_* held stable.
  - APBM_PREADY=1: capture APBM_PRDATA, capture PSLVERR=APBM_PSLVERR, then RESP.
  - Else if TIMEOUT!=0 and counter==TIMEOUT-1: abort. Capture PRDATA=0, PSLVERR=1, pulse TIMEOUT_EVT, then RESP.
  - Else increment counter.
  - APBM_PREADY has precedence over timeout in the same cycle.
  - On leaving ACCESS, APBM_PSEL and APBM_PENABLE are 0 in RESP.
- RESP (one cycle):
  - APBS_PREADY[g]=1 and APBS_PSLVERR[g]=captured value; APBS_PRDATA=captured data.
  - All other requesters see PREADY=0 and PSLVERR=0.
  - Next state is always IDLE. The requester drops PSEL during this cycle; the IDLE cycle guarantees that a stale PSEL is never re-granted.
- APBS_PRDATA holds its value until the next capture.
- GRANT is nonzero in SETUP, ACCESS and RESP.
- Latency: PSEL seen in IDLE at cycle n gives SETUP n+1, ACCESS n+2, earliest APBS_PREADY at n+3 (zero-wait target). Minimum period per transfer is 4 cycles.
- Requests arriving outside IDLE wait.
- Requester inputs change only in IDLE sampling; later changes are ignored until the next grant.
- Simultaneous requests: exactly one grant; the others are served in rotation order. No starvation: each waiter is served within NS grants.
- Watchdog: ACCESS cycles before abort = TIMEOUT. Counter width = clog2(TIMEOUT+1); no wrap is possible.

Test Plan:
- Single read, requester 2, target PREADY at first ACCESS cycle with PRDATA=0xDEADBEEF -> APBM_PADDR=req2 address; APBS_PREADY=0b0100 three cycles after request; APBS_PRDATA=0xDEADBEEF; PSLVERR=0.
- All four PSEL held continuously after reset -> grant order 0,1,2,3,0; each grant 4 cycles apart with zero-wait target.
- Requester 1 writes 0x1234 at 0x0040; target inserts 3 wait states then PSLVERR=1 -> APBM_PWDATA=0x1234 stable for all 4 ACCESS cycles; APBS_PSLVERR[1]=1 with PREADY[1].
- TIMEOUT=8, target never ready -> abort after 8 ACCESS cycles; TIMEOUT_EVT single pulse; PSLVERR=1, PRDATA=0; next request is granted normally.
- RESET asserted during ACCESS -> next cycle APBM_PSEL=0, GRANT=0, no APBS_PREADY; after release, requester 0 wins over requester 3 when both are pending.
- TIMEOUT=0 with a 1000-cycle wait target -> no abort; completes on PREADY.
